pitch_angle_tracker: RTL and testbench

Downstream stage of `gimbal30km`: consumes its signed angular-velocity output and integrates it into a vehicle pitch angle, one step per fixed time tick. Owns a small flight-phase FSM (idle, tracking, saturated, done), optional rate clamping, and a per-step valid strobe. Its output feeds trajectory logging and any later attitude logic.

---
 rtl/pitch_pkg.sv | 22 ++
 rtl/tick_divider.sv | 43 ++++
 rtl/pitch_angle_tracker.sv | 137 +++++++++++++
 tb/tb_pitch_angle_tracker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch angle tracker: flight-phase state encoding,
// unit scales and default limits.
package pitch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_SAT   = 2'd2,
    ST_DONE  = 2'd3
  } pitch_state_e;

  localparam longint UDEG_PER_DEG = 1_000_000;
  localparam longint MDEG_PER_DEG = 1_000;

  localparam int     DEF_N              = 64;
  localparam int     DEF_DIV            = 1000;
  localparam longint DEF_DT_MS          = 1;
  localparam longint DEF_MAX_PITCH_UDEG = 90 * UDEG_PER_DEG;
  localparam longint DEF_MAX_RATE_MDEGS = 5 * MDEG_PER_DEG;
  localparam int     DEF_STEPS          = 168_000;

endpackage

// File: rtl/tick_divider.sv
// Integration tick generator: counts 0..DIV-1 and flags the last count.
// A synchronous clear holds the count at zero.
module tick_divider #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("tick_divider: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pitch_angle_tracker.sv
// Integrates signed angular velocity (mdeg/s) into a pitch angle (udeg) once per tick,
// with saturation and a burnout step limit. Optional rate clamp: PITCH_RATE_LIMIT_EN.
module pitch_angle_tracker
  import pitch_pkg::*;
#(
  parameter int     N              = DEF_N,
  parameter int     DIV            = DEF_DIV,
  parameter longint DT_MS          = DEF_DT_MS,
  parameter longint MAX_PITCH_UDEG = DEF_MAX_PITCH_UDEG,
  parameter longint MAX_RATE_MDEGS = DEF_MAX_RATE_MDEGS,
  parameter int     STEPS          = DEF_STEPS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [N-1:0] angular_velocity,
  output logic signed [N-1:0] pitch_udeg,
  output logic                angle_valid,
  output logic                saturated,
  output logic                done,
  output logic [31:0]         step_count,
  output logic [1:0]          state_dbg
);

  localparam logic signed [N-1:0] DT_W  = N'(DT_MS);
  localparam logic signed [N:0]   LIM_P = (N + 1)'(MAX_PITCH_UDEG);
  localparam logic signed [N:0]   LIM_N = -LIM_P;
  localparam logic [31:0]         STEPS_W = 32'(STEPS);

  if (MAX_RATE_MDEGS < 0) begin : g_rate_check
    $error("pitch_angle_tracker: MAX_RATE_MDEGS must be non-negative");
  end

  pitch_state_e        state_q, state_d;
  logic signed [N-1:0] pitch_q, pitch_d;
  logic                valid_q, valid_d;
  logic                sat_q, sat_d;
  logic [31:0]         step_q, step_d;

  logic                tick;
  logic                div_clear;
  logic signed [N-1:0] rate;
  logic signed [N-1:0] inc;
  logic signed [N:0]   sum;

  assign div_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .tick  (tick)
  );

`ifdef PITCH_RATE_LIMIT_EN
  localparam logic signed [N-1:0] RATE_MAX = N'(MAX_RATE_MDEGS);

  always_comb begin
    rate = angular_velocity;
    if (angular_velocity > RATE_MAX) begin
      rate = RATE_MAX;
    end else if (angular_velocity < -RATE_MAX) begin
      rate = -RATE_MAX;
    end
  end
`else
  assign rate = angular_velocity;
`endif

  // mdeg/s times ms gives udeg; the sum carries one extra bit so the limit test cannot wrap.
  assign inc = rate * DT_W;
  assign sum = {pitch_q[N-1], pitch_q} + {inc[N-1], inc};

  always_comb begin
    state_d = state_q;
    pitch_d = pitch_q;
    sat_d   = sat_q;
    step_d  = step_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_TRACK;
        end
      end
      ST_TRACK, ST_SAT: begin
        if (step_q == STEPS_W) begin
          state_d = ST_DONE;
        end else if (tick) begin
          if (sum > LIM_P) begin
            pitch_d = LIM_P[N-1:0];
            sat_d   = 1'b1;
          end else if (sum < LIM_N) begin
            pitch_d = LIM_N[N-1:0];
            sat_d   = 1'b1;
          end else begin
            pitch_d = sum[N-1:0];
            sat_d   = 1'b0;
          end
          state_d = sat_d ? ST_SAT : ST_TRACK;
          step_d  = step_q + 32'd1;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pitch_q <= '0;
      sat_q   <= 1'b0;
      step_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pitch_q <= pitch_d;
      sat_q   <= sat_d;
      step_q  <= step_d;
      valid_q <= valid_d;
    end
  end

  // angle_valid is a one-cycle strobe with no backpressure: consumers must take pitch_udeg that cycle.
  assign pitch_udeg  = pitch_q;
  assign angle_valid = valid_q;
  assign saturated   = sat_q;
  assign done        = (state_q == ST_DONE);
  assign step_count  = step_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pitch_angle_tracker.sv
// Directed bench for pitch_angle_tracker with DIV=4, limit 25000 udeg, STEPS=14.
// Expectations follow PITCH_RATE_LIMIT_EN when the bench is built with it.
module tb_pitch_angle_tracker;
  import pitch_pkg::*;

  localparam int     N     = 64;
  localparam int     DIV   = 4;
  localparam longint DT    = 1;
  localparam longint LIM   = 25000;
  localparam longint RMAX  = 1000;
  localparam int     STEPS = 14;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic signed [N-1:0] av = '0;
  logic signed [N-1:0] pitch_udeg;
  logic                angle_valid;
  logic                saturated;
  logic                done;
  logic [31:0]         step_count;
  logic [1:0]          state_dbg;

  int     n_pass = 0;
  int     n_total = 0;
  longint exp_pitch = 0;
  int     exp_steps = 0;
  logic   exp_sat = 1'b0;

  always #5 clk = ~clk;

  pitch_angle_tracker #(
    .N              (N),
    .DIV            (DIV),
    .DT_MS          (DT),
    .MAX_PITCH_UDEG (LIM),
    .MAX_RATE_MDEGS (RMAX),
    .STEPS          (STEPS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .angular_velocity (av),
    .pitch_udeg       (pitch_udeg),
    .angle_valid      (angle_valid),
    .saturated        (saturated),
    .done             (done),
    .step_count       (step_count),
    .state_dbg        (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pitch"}, pitch_udeg, 64'd0);
    check({tag, "_valid"}, angle_valid, 64'd0);
    check({tag, "_sat"}, saturated, 64'd0);
    check({tag, "_done"}, done, 64'd0);
    check({tag, "_steps"}, step_count, 64'd0);
    check({tag, "_state"}, state_dbg, 64'(ST_IDLE));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    exp_pitch = 0;
    exp_steps = 0;
    exp_sat = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_state", state_dbg, 64'(ST_TRACK));
    check("start_valid", angle_valid, 64'd0);
  endtask

  // One tick period: the rate is only presented shortly before the tick edge and
  // replaced by junk afterwards, so any off-tick sampling shows up in the pitch.
  task automatic step(input longint rate);
    longint r;
    longint s;
    for (int i = 0; i < DIV - 1; i++) begin
      @(posedge clk);
      #1;
      check("gap_valid", angle_valid, 64'd0);
      if (i == 1) av = rate;
    end
    r = rate;
`ifdef PITCH_RATE_LIMIT_EN
    if (r > RMAX) r = RMAX;
    if (r < -RMAX) r = -RMAX;
`endif
    s = exp_pitch + r * DT;
    if (s > LIM) begin
      exp_pitch = LIM;
      exp_sat = 1'b1;
    end else if (s < -LIM) begin
      exp_pitch = -LIM;
      exp_sat = 1'b1;
    end else begin
      exp_pitch = s;
      exp_sat = 1'b0;
    end
    exp_steps++;
    @(posedge clk);
    #1;
    check("tick_valid", angle_valid, 64'd1);
    check("tick_pitch", pitch_udeg, exp_pitch);
    check("tick_sat", saturated, 64'(exp_sat));
    check("tick_steps", step_count, 64'(exp_steps));
    check("tick_done", done, 64'd0);
    check("tick_state", state_dbg, exp_sat ? 64'(ST_SAT) : 64'(ST_TRACK));
    av = $signed(64'($urandom_range(0, 200000))) - 64'sd100000;
  endtask

  initial begin
    do_reset(3);
    repeat (5 * DIV) begin
      @(posedge clk);
      #1;
      check("idle_valid", angle_valid, 64'd0);
      check("idle_pitch", pitch_udeg, 64'd0);
    end
    check_zero("idle_end");

    do_start();
    repeat (10) step(2000);
`ifdef PITCH_RATE_LIMIT_EN
    check("ten_ticks_pitch", pitch_udeg, 64'sd10000);
`else
    check("ten_ticks_pitch", pitch_udeg, 64'sd20000);
`endif
    check("ten_ticks_steps", step_count, 64'd10);

    repeat (3) step(2000);
`ifdef PITCH_RATE_LIMIT_EN
    check("pos_clamp_pitch", pitch_udeg, 64'sd13000);
    check("pos_clamp_sat", saturated, 64'd0);
`else
    check("pos_clamp_pitch", pitch_udeg, 64'sd25000);
    check("pos_clamp_sat", saturated, 64'd1);
`endif
    step(-3000);
`ifdef PITCH_RATE_LIMIT_EN
    check("unclamp_pitch", pitch_udeg, 64'sd12000);
`else
    check("unclamp_pitch", pitch_udeg, 64'sd22000);
`endif
    check("unclamp_sat", saturated, 64'd0);

    @(posedge clk);
    #1;
    check("done_rise", done, 64'd1);
    check("done_state", state_dbg, 64'(ST_DONE));
    check("done_valid", angle_valid, 64'd0);
    start = 1'b1;
    repeat (3 * DIV) begin
      @(posedge clk);
      #1;
      check("done_hold_valid", angle_valid, 64'd0);
      check("done_hold_pitch", pitch_udeg, exp_pitch);
      check("done_hold_steps", step_count, 64'd14);
      check("done_hold_done", done, 64'd1);
    end
    start = 1'b0;

    do_reset(1);
    do_start();
    repeat (3) step(7000);
`ifdef PITCH_RATE_LIMIT_EN
    check("rate7000_pitch", pitch_udeg, 64'sd3000);
`else
    check("rate7000_pitch", pitch_udeg, 64'sd21000);
`endif
    start = 1'b1;
    repeat (6) step(-8000);
    start = 1'b0;
`ifdef PITCH_RATE_LIMIT_EN
    check("neg_clamp_pitch", pitch_udeg, -64'sd3000);
    check("neg_clamp_sat", saturated, 64'd0);
`else
    check("neg_clamp_pitch", pitch_udeg, -64'sd25000);
    check("neg_clamp_sat", saturated, 64'd1);
    check("neg_clamp_state", state_dbg, 64'(ST_SAT));
`endif

    repeat (2) @(posedge clk);
    do_reset(1);
    do_start();
    step(500);
    check("restart_pitch", pitch_udeg, 64'sd500);
    check("restart_steps", step_count, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
